// File: rtl/svga_timing_out.sv
// SVGA timing generator with registered colour/sync output and Tiny VGA PMOD mapping.
// Optional colour-bar source built when SVGA_TEST_PATTERN_EN is defined (adds test_mode input).
module svga_timing_out #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int COLOR_BITS = 2,
    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL),
    localparam int CW        = 3 * COLOR_BITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
`ifdef SVGA_TEST_PATTERN_EN
    input  logic          test_mode,
`endif
    input  logic [CW-1:0] pixel_rgb,
    output logic [HW-1:0] x_pos,
    output logic [VW-1:0] y_pos,
    output logic          active,
    output logic [CW-1:0] rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          next_vertical,
    output logic          next_frame,
    output logic [7:0]    pmod_out
);

    localparam int LO = (COLOR_BITS > 1) ? COLOR_BITS - 2 : COLOR_BITS - 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          h_sync_win;
    logic          v_sync_win;
    logic [CW-1:0] color;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // Widened compares so a window ending exactly at the total cannot wrap.
    assign h_sync_win = ({1'b0, h_cnt} >= (HW+1)'(H_ACTIVE + H_FRONT)) &&
                        ({1'b0, h_cnt} <  (HW+1)'(H_ACTIVE + H_FRONT + H_SYNC));
    assign v_sync_win = ({1'b0, v_cnt} >= (VW+1)'(V_ACTIVE + V_FRONT)) &&
                        ({1'b0, v_cnt} <  (VW+1)'(V_ACTIVE + V_FRONT + V_SYNC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign x_pos         = h_cnt;
    assign y_pos         = v_cnt;
    assign active        = ({1'b0, h_cnt} < (HW+1)'(H_ACTIVE)) &&
                           ({1'b0, v_cnt} < (VW+1)'(V_ACTIVE));
    assign next_vertical = enable && h_last;
    assign next_frame    = next_vertical && v_last;

`ifdef SVGA_TEST_PATTERN_EN
    // Eight equal-width bars across the visible line; index bits select R/G/B.
    logic [HW+2:0] bar_full;
    logic [2:0]    bar;
    logic [CW-1:0] pattern;

    assign bar_full = {h_cnt, 3'b000} / (HW+3)'(H_ACTIVE);
    assign bar      = bar_full[2:0];
    assign pattern  = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
    assign color    = test_mode ? pattern : pixel_rgb;
`else
    assign color    = pixel_rgb;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb   <= '0;
            hsync <= ~H_SYNC_POL;
            vsync <= ~V_SYNC_POL;
        end else begin
            rgb   <= (enable && active) ? color : '0;
            hsync <= (enable && h_sync_win) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync <= (enable && v_sync_win) ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

    // Only the top two bits of each channel reach the PMOD; 1-bit colour repeats its msb.
    logic [COLOR_BITS-1:0] r_ch;
    logic [COLOR_BITS-1:0] g_ch;
    logic [COLOR_BITS-1:0] b_ch;

    assign r_ch = rgb[CW-1 -: COLOR_BITS];
    assign g_ch = rgb[2*COLOR_BITS-1 -: COLOR_BITS];
    assign b_ch = rgb[COLOR_BITS-1:0];

    assign pmod_out = {hsync, b_ch[LO], g_ch[LO], r_ch[LO],
                       vsync, b_ch[COLOR_BITS-1], g_ch[COLOR_BITS-1], r_ch[COLOR_BITS-1]};

endmodule
